// File: rtl/circuit2_seq.sv
// circuit2 dataflow (d, e, f, compare, g, h, x, z) scheduled over one shared
// adder/subtractor and one comparator, one operation per FSM state.
module circuit2_seq #(
   parameter int unsigned DATAWIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] x,
   output logic [DATAWIDTH-1:0] z
);

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 3'd0,
      S_D    = 3'd1,
      S_E    = 3'd2,
      S_F    = 3'd3,
      S_CMP  = 3'd4,
      S_GH   = 3'd5,
      S_SH   = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t state_q, state_d;

   // Operand copies and intermediates
   logic [DATAWIDTH-1:0] a_q, b_q, c_q;
   logic [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q;
   logic [DATAWIDTH-1:0] g_d, h_d, x_d, z_d;
   logic [DATAWIDTH-1:0] x_q, z_q;
   logic                 dlte_q, deqe_q;

   // Per-state control decoded from the state register
   logic                 cap_en, d_en, e_en, f_en, cmp_en, gh_en, sh_en;
   logic                 au_sub;
   logic [DATAWIDTH-1:0] au_opb;
   logic [DATAWIDTH-1:0] au_y;
   logic                 cmp_lt, cmp_eq;

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: strictly linear schedule, start only honoured in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_D;
         S_D:     state_d = S_E;
         S_E:     state_d = S_F;
         S_F:     state_d = S_CMP;
         S_CMP:   state_d = S_GH;
         S_GH:    state_d = S_SH;
         S_SH:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      cap_en = 1'b0;
      d_en   = 1'b0;
      e_en   = 1'b0;
      f_en   = 1'b0;
      cmp_en = 1'b0;
      gh_en  = 1'b0;
      sh_en  = 1'b0;
      au_sub = 1'b0;
      au_opb = '0;
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_DONE);
      case (state_q)
         S_IDLE: cap_en = start;
         S_D: begin
            d_en   = 1'b1;
            au_opb = b_q;
         end
         S_E: begin
            e_en   = 1'b1;
            au_opb = c_q;
         end
         S_F: begin
            f_en   = 1'b1;
            au_sub = 1'b1;
            au_opb = b_q;
         end
         S_CMP:   cmp_en = 1'b1;
         S_GH:    gh_en  = 1'b1;
         S_SH:    sh_en  = 1'b1;
         default: ;
      endcase
   end

   // Shared adder/subtractor; the left operand is always a
   assign au_y = au_sub ? (a_q - au_opb) : (a_q + au_opb);

   // Shared unsigned comparator
   assign cmp_lt = (d_q < e_q);
   assign cmp_eq = (d_q == e_q);

   // h consumes the freshly selected g in the same cycle
   assign g_d = dlte_q ? d_q : e_q;
   assign h_d = deqe_q ? g_d : f_q;

   // Shift by the 1-bit flags: logical, zero fill
   assign x_d = dlte_q ? {g_q[DATAWIDTH-2:0], 1'b0} : g_q;
   assign z_d = deqe_q ? {1'b0, h_q[DATAWIDTH-1:1]} : h_q;

   // Operand capture
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else if (cap_en) begin
         a_q <= a;
         b_q <= b;
         c_q <= c;
      end
   end

   // Arithmetic intermediates from the shared unit
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         d_q <= '0;
         e_q <= '0;
         f_q <= '0;
      end else begin
         if (d_en) d_q <= au_y;
         if (e_en) e_q <= au_y;
         if (f_en) f_q <= au_y;
      end
   end

   // Comparison flags and selected values
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dlte_q <= 1'b0;
         deqe_q <= 1'b0;
         g_q    <= '0;
         h_q    <= '0;
      end else begin
         if (cmp_en) begin
            dlte_q <= cmp_lt;
            deqe_q <= cmp_eq;
         end
         if (gh_en) begin
            g_q <= g_d;
            h_q <= h_d;
         end
      end
   end

   // Results hold until the next shift step or reset
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         x_q <= '0;
         z_q <= '0;
      end else if (sh_en) begin
         x_q <= x_d;
         z_q <= z_d;
      end
   end

   assign x = x_q;
   assign z = z_q;

endmodule

// File: tb/tb_circuit2_seq.sv
// Directed bench for circuit2_seq: scoreboard of expected x/z pushed at start,
// popped and compared when done pulses; latency, busy and handshake checks.
module tb_circuit2_seq;

   localparam int unsigned W = 32;

   logic         Clk;
   logic         Rst;
   logic         start;
   logic [W-1:0] a, b, c;
   logic         busy, done;
   logic [W-1:0] x, z;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] z;
   } res_t;

   res_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   circuit2_seq #(.DATAWIDTH(W)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .x     (x),
      .z     (z)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model of the circuit2 dataflow
   function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic [W-1:0] ic);
      logic [W-1:0] d, e, f, g, h;
      logic         lt, eq;
      res_t         r;
      d = ia + ib;
      e = ia + ic;
      f = ia - ib;
      lt = (d < e);
      eq = (d == e);
      g = lt ? d : e;
      h = eq ? g : f;
      r.x = lt ? (g << 1) : g;
      r.z = eq ? (h >> 1) : h;
      return r;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Called one sample after the accepting edge; optionally pulses start in S_E
   task automatic wait_done(input string tag, input bit pulse_in_e);
      int   k;
      int   nbusy;
      res_t exp;
      nbusy = 0;
      for (k = 0; k < 20; k++) begin
         if (busy) nbusy++;
         if (done) break;
         if (pulse_in_e && k == 1) begin
            start = 1'b1;
            a = 32'h1234_5678;
            b = 32'h0000_0001;
            c = 32'h8000_0000;
         end else if (pulse_in_e && k == 2) begin
            start = 1'b0;
         end
         step();
      end
      chk({tag, "_done_seen"}, W'(done), W'(1));
      chk({tag, "_latency"}, W'(k), W'(6));
      chk({tag, "_busy_cycles"}, W'(nbusy), W'(7));
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         chk({tag, "_x"}, x, exp.x);
         chk({tag, "_z"}, z, exp.z);
      end else begin
         chk({tag, "_sb_nonempty"}, W'(0), W'(1));
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input bit pulse_in_e);
      res_t exp;
      start = 1'b1;
      a = ia;
      b = ib;
      c = ic;
      exp = model(ia, ib, ic);
      sb_q.push_back(exp);
      step();
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      c = $urandom;
      wait_done(tag, pulse_in_e);
      step();
      chk({tag, "_done_one_cycle"}, W'(done), W'(0));
      chk({tag, "_idle_after"}, W'(busy), W'(0));
      chk({tag, "_x_hold"}, x, exp.x);
      chk({tag, "_z_hold"}, z, exp.z);
   endtask

   initial begin
      res_t exp;
      int   nd;
      Rst   = 1'b0;
      start = 1'b1;
      a = $urandom;
      b = $urandom;
      c = $urandom;

      // Reset held with start asserted
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_busy", W'(busy), W'(0));
         chk("rst_done", W'(done), W'(0));
         chk("rst_x", x, '0);
         chk("rst_z", z, '0);
      end
      start = 1'b0;
      Rst   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_no_start", W'(busy), W'(0));
      end

      // Directed datapath cases
      run_op("basic", 32'd5, 32'd3, 32'd2, 1'b0);
      chk("basic_x_const", x, 32'd7);
      chk("basic_z_const", z, 32'd2);
      run_op("lt_borrow", 32'd1, 32'd2, 32'd4, 1'b0);
      chk("lt_x_const", x, 32'd6);
      chk("lt_z_const", z, 32'hFFFF_FFFF);
      run_op("equal", 32'd10, 32'd4, 32'd4, 1'b0);
      chk("eq_x_const", x, 32'd14);
      chk("eq_z_const", z, 32'd7);
      run_op("wrap", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      chk("wrap_x_const", x, 32'd0);
      chk("wrap_z_const", z, 32'hFFFF_FFFE);

      // start pulsed in S_E with new operands is ignored
      run_op("ignore", 32'd5, 32'd3, 32'd2, 1'b1);

      // start held high: re-accepted in the IDLE cycle after done
      start = 1'b1;
      a = 32'd100; b = 32'd7; c = 32'd7;
      sb_q.push_back(model(32'd100, 32'd7, 32'd7));
      step();
      wait_done("held1", 1'b0);
      a = 32'd3; b = 32'd9; c = 32'd1;
      sb_q.push_back(model(32'd3, 32'd9, 32'd1));
      step();
      chk("held_idle_busy", W'(busy), W'(0));
      chk("held_idle_done", W'(done), W'(0));
      step();
      chk("held_reaccept", W'(busy), W'(1));
      start = 1'b0;
      wait_done("held2", 1'b0);
      step();

      // Random operands
      for (int i = 0; i < 3; i++) begin
         run_op("rand", $urandom, $urandom, $urandom, 1'b0);
      end

      // Known nonzero result before the abort
      run_op("pre_abort", 32'd5, 32'd3, 32'd2, 1'b0);

      // Reset asserted in S_GH aborts: no done, results cleared
      start = 1'b1;
      a = 32'd1; b = 32'd2; c = 32'd4;
      sb_q.push_back(model(32'd1, 32'd2, 32'd4));
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      Rst = 1'b0;
      #1;
      exp = sb_q.pop_front();
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_x", x, '0);
      chk("abort_z", z, '0);
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) nd++;
      end
      Rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) nd++;
      end
      chk("abort_no_done", W'(nd), W'(0));
      chk("abort_x_after", x, '0);
      chk("abort_z_after", z, '0);

      // Recovery after abort
      run_op("recover", 32'd10, 32'd4, 32'd4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
